// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the register-file write-port arbiter:
//   - arb_state_e  : arbiter FSM state encoding (IDLE / WAIT / STEAL)
//   - WB_REGWRITE / WB_MEMTOREG : bit positions inside the MEM/WB control field
//   - mdu_entry_t  : one buffered MDU result {live, rd, data}
//   - onehot_rd()  : 5-bit register index to 32-bit one-hot mask
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEAL = 2'd2
    } arb_state_e;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } mdu_entry_t;

    function automatic logic [31:0] onehot_rd(input logic [4:0] rd);
        logic [31:0] m;
        m = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mdu_result_q.sv
// ---------------------------------------------------------------------------
// mdu_result_q
// Small in-order FIFO of MDU results. Entry 0 is always the head; a pop
// shifts the remaining entries down. Entries can be killed (marked dead)
// by destination register, and the live entries produce a pending mask.
//
// Ports:
//   clock, reset_n      clock / asynchronous active-low reset
//   push_i              accept an entry this cycle (caller guarantees not full)
//   push_rd_i/_data_i   destination and value of the pushed result
//   pop_i               remove the head this cycle
//   kill_i, kill_rd_i   mark every stored entry with rd == kill_rd_i dead
//   head_o              current head entry
//   count_o             registered occupancy
//   count_next_o        occupancy after this cycle's push/pop
//   pend_mask_o         OR of one-hot rd over live stored entries
// ---------------------------------------------------------------------------
module mdu_result_q
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [4:0]       push_rd_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    input  logic             kill_i,
    input  logic [4:0]       kill_rd_i,
    output mdu_entry_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic [31:0]      pend_mask_o
);

    mdu_entry_t       ent_q [DEPTH];
    mdu_entry_t       ent_d [DEPTH];
    mdu_entry_t       ent_k [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] cnt_pop;
    logic             push_live;

    always_comb begin
        // A result destined for x0 is accepted but never stored.
        push_live = push_i && (push_rd_i != 5'd0);

        // Kill only looks at already-stored entries, so an entry pushed in
        // the same cycle survives.
        for (int i = 0; i < DEPTH; i++) begin
            ent_k[i] = ent_q[i];
            if (kill_i && (ent_q[i].rd == kill_rd_i)) begin
                ent_k[i].live = 1'b0;
            end
        end

        cnt_pop = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_k[i];
        end
        if (pop_i && (count_q != '0)) begin
            cnt_pop = count_q - 1'b1;
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_k[i + 1];
            end
            ent_d[DEPTH - 1] = '0;
        end

        count_d = cnt_pop;
        if (push_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_pop == CNT_W'(i)) begin
                    ent_d[i].live = 1'b1;
                    ent_d[i].rd   = push_rd_i;
                    ent_d[i].data = push_data_i;
                end
            end
            count_d = cnt_pop + 1'b1;
        end

        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && ent_q[i].live) begin
                pend_mask_o = pend_mask_o | onehot_rd(ent_q[i].rd);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign head_o       = ent_q[0];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the MEM/WB pipeline
// writeback (priority) and buffered MDU results. MDU results drain into idle
// writeback slots; a head that has waited MAX_WAIT cycles forces a one-cycle
// STEAL that stalls the pipeline and writes the head instead.
//
// Handshake: an MDU result transfers on a rising clock edge where
// mdu_valid && mdu_ready; mdu_ready depends only on registered occupancy.
//
// Ports:
//   clock, reset_n              clock / asynchronous active-low reset
//   wb_ctl, wb_mem, wb_alu, wb_rd   MEM/WB writeback fields
//   mdu_valid, mdu_ready, mdu_rd, mdu_data   MDU result handshake
//   rf_we, rf_wa, rf_wd          register-file write port (combinational)
//   pipe_stall                   hold MEM/WB and earlier stages (STEAL only)
//   pend_mask                    registers with a live buffered MDU write
//   dbg_state                    arbiter FSM state
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  wb_ctl,
    input  logic [31:0] wb_mem,
    input  logic [31:0] wb_alu,
    input  logic [4:0]  wb_rd,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pipe_stall,
    output logic [31:0] pend_mask,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    arb_state_e       state_q, state_d;
    logic [7:0]       age_q, age_d;
    logic             pwr;
    logic [31:0]      pipe_data;
    mdu_entry_t       head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             q_full;
    logic             q_nonempty;
    logic             push, pop, kill;
    logic             we_c;
    logic [4:0]       wa_c;
    logic [31:0]      wd_c;

    assign pwr        = wb_ctl[WB_REGWRITE] && (wb_rd != 5'd0);
    assign pipe_data  = wb_ctl[WB_MEMTOREG] ? wb_mem : wb_alu;
    assign q_full     = (count == CNT_W'(DEPTH));
    assign q_nonempty = (count != '0);

    // Held low during reset even though the empty queue would say "ready".
    assign mdu_ready  = reset_n && !q_full;
    assign push       = mdu_valid && mdu_ready;

    mdu_result_q #(.DEPTH(DEPTH)) u_q (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (push),
        .push_rd_i    (mdu_rd),
        .push_data_i  (mdu_data),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_rd_i    (wb_rd),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next),
        .pend_mask_o  (pend_mask)
    );

    // Port grant: STEAL first, then the pipeline, then an idle-slot drain.
    always_comb begin
        we_c = 1'b0;
        wa_c = '0;
        wd_c = '0;
        pop  = 1'b0;
        kill = 1'b0;
        if (state_q == ST_STEAL) begin
            pop  = q_nonempty;
            we_c = q_nonempty && head.live;
            wa_c = head.rd;
            wd_c = head.data;
        end else if (pwr) begin
            we_c = 1'b1;
            wa_c = wb_rd;
            wd_c = pipe_data;
            // The pipeline instruction is younger than any buffered result.
            kill = 1'b1;
        end else if (q_nonempty) begin
            pop  = 1'b1;
            we_c = head.live;
            wa_c = head.rd;
            wd_c = head.data;
        end
    end

    assign rf_we = reset_n && we_c;
    assign rf_wa = reset_n ? wa_c : 5'd0;
    assign rf_wd = reset_n ? wd_c : 32'd0;

    // Age of the current head: restarts whenever a new entry becomes head
    // (pop, or a push into an empty queue), saturates at MAX_WAIT.
    always_comb begin
        if (!q_nonempty || pop) begin
            age_d = '0;
        end else if (age_q != 8'(MAX_WAIT)) begin
            age_d = age_q + 8'd1;
        end else begin
            age_d = age_q;
        end
    end

    // STEAL is entered so that it coincides with the cycle in which the
    // head's age equals MAX_WAIT; the head can only age while pwr holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_next != '0) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_next == '0) begin
                    state_d = ST_IDLE;
                end else if (pwr && (age_d == 8'(MAX_WAIT))) begin
                    state_d = ST_STEAL;
                end
            end
            ST_STEAL: begin
                state_d = (count_next != '0) ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end

    assign pipe_stall = (state_q == ST_STEAL);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int MW = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  wb_ctl = '0;
  logic [31:0] wb_mem = '0;
  logic [31:0] wb_alu = '0;
  logic [4:0]  wb_rd = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pipe_stall;
  logic [31:0] pend_mask;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  wb_port_arbiter #(.MAX_WAIT(MW), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_ctl(wb_ctl), .wb_mem(wb_mem), .wb_alu(wb_alu), .wb_rd(wb_rd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wb_ctl = '0; wb_mem = '0; wb_alu = '0; wb_rd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // driver
  task automatic drive(input logic [1:0] ctl, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic v, input logic [4:0] mrd,
                       input logic [31:0] mdat);
    wb_ctl = ctl; wb_rd = rd; wb_alu = alu; wb_mem = mem;
    mdu_valid = v; mdu_rd = mrd; mdu_data = mdat;
  endtask

  // comparison
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // table of pipeline-only vectors (queue empty)
  typedef struct {
    logic [1:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [31:0] alu;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [7];

  // reference model state for the random phase
  int          q_rd [$];
  logic [31:0] q_data [$];
  bit          q_live [$];
  int          head_t;
  int          cyc;

  initial begin
    vecs[0] = '{2'b10, 5'd5,  32'h0000_BEEF, 32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{2'b10, 5'd0,  32'h0000_BEEF, 32'h0000_1234, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{2'b11, 5'd5,  32'h0000_ABCD, 32'h0000_1234, 1'b1, 5'd5,  32'h0000_ABCD};
    vecs[3] = '{2'b01, 5'd5,  32'h0000_ABCD, 32'h0000_1234, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{2'b00, 5'd9,  32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0,  32'h0};
    vecs[5] = '{2'b11, 5'd31, 32'hDEAD_0001, 32'h5555_5555, 1'b1, 5'd31, 32'hDEAD_0001};
    vecs[6] = '{2'b10, 5'd1,  32'h7777_7777, 32'hFFFF_FFFF, 1'b1, 5'd1,  32'hFFFF_FFFF};

    // reset state
    do_reset();
    #2;
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick();

    // pipeline-only table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].ctl, vecs[i].rd, vecs[i].alu, vecs[i].mem, 1'b0, 5'd0, 32'd0);
      #2;
      chk("tbl_we", 32'(rf_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk("tbl_wa", 32'(rf_wa), 32'(vecs[i].exp_wa));
        chk("tbl_wd", rf_wd, vecs[i].exp_wd);
      end
      chk("tbl_stall", 32'(pipe_stall), 32'd0);
      tick();
    end

    // idle drain
    drive(2'b00, 5'd0, 0, 0, 1'b1, 5'd7, 32'h0000_CAFE);
    #2;
    chk("drain_ready", 32'(mdu_ready), 32'd1);
    chk("drain_we0", 32'(rf_we), 32'd0);
    tick();
    drive(2'b00, 5'd0, 0, 0, 1'b0, 5'd0, 0);
    #2;
    chk("drain_we", 32'(rf_we), 32'd1);
    chk("drain_wa", 32'(rf_wa), 32'd7);
    chk("drain_wd", rf_wd, 32'h0000_CAFE);
    chk("drain_pend", pend_mask, 32'h0000_0080);
    tick();
    #2;
    chk("drain_pend0", pend_mask, 32'd0);
    chk("drain_idle", 32'(dbg_state), 32'd0);
    chk("drain_we_after", 32'(rf_we), 32'd0);
    tick();

    // starvation steal
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd9, 32'h99);
    #2;
    chk("stv_c0_wa", 32'(rf_wa), 32'd5);
    tick();
    drive(2'b10, 5'd5, 32'h55, 0, 1'b0, 5'd0, 0);
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk("stv_nostall", 32'(pipe_stall), 32'd0);
      chk("stv_pipe_wa", 32'(rf_wa), 32'd5);
      tick();
    end
    #2;
    chk("stv_stall", 32'(pipe_stall), 32'd1);
    chk("stv_we", 32'(rf_we), 32'd1);
    chk("stv_wa", 32'(rf_wa), 32'd9);
    chk("stv_wd", rf_wd, 32'h99);
    tick();
    #2;
    chk("stv_unstall", 32'(pipe_stall), 32'd0);
    chk("stv_held_wa", 32'(rf_wa), 32'd5);
    chk("stv_held_wd", rf_wd, 32'h55);
    chk("stv_pend", pend_mask, 32'd0);
    chk("stv_idle", 32'(dbg_state), 32'd0);
    tick();

    // full queue
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd3, 32'h33);
    #2; chk("full_c0_ready", 32'(mdu_ready), 32'd1); tick();
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd4, 32'h44);
    #2; chk("full_c1_ready", 32'(mdu_ready), 32'd1); tick();
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd10, 32'hAA);
    #2;
    chk("full_ready0", 32'(mdu_ready), 32'd0);
    chk("full_pend", pend_mask, 32'h0000_0018);
    tick();
    #2;
    chk("full_c3_ready", 32'(mdu_ready), 32'd0);
    chk("full_c3_stall", 32'(pipe_stall), 32'd0);
    tick();
    #2;
    chk("full_steal", 32'(pipe_stall), 32'd1);
    chk("full_steal_wa", 32'(rf_wa), 32'd3);
    chk("full_steal_wd", rf_wd, 32'h33);
    chk("full_steal_ready", 32'(mdu_ready), 32'd0);
    tick();
    #2;
    chk("full_c5_ready", 32'(mdu_ready), 32'd1);
    chk("full_c5_pend", pend_mask, 32'h0000_0010);
    tick();
    drive(2'b00, 5'd0, 0, 0, 1'b0, 5'd0, 0);
    #2;
    chk("full_c6_pend", pend_mask, 32'h0000_0410);
    chk("full_c6_wa", 32'(rf_wa), 32'd4);
    chk("full_c6_we", 32'(rf_we), 32'd1);
    tick();
    #2;
    chk("full_c7_wa", 32'(rf_wa), 32'd10);
    chk("full_c7_wd", rf_wd, 32'hAA);
    tick();
    #2;
    chk("full_c8_we", 32'(rf_we), 32'd0);
    chk("full_c8_pend", pend_mask, 32'd0);
    tick();

    // WAW kill
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd6, 32'h66);
    tick();
    drive(2'b10, 5'd6, 32'h77, 0, 1'b0, 5'd0, 0);
    #2;
    chk("waw_pend_before", pend_mask, 32'h0000_0040);
    chk("waw_pipe_wa", 32'(rf_wa), 32'd6);
    chk("waw_pipe_wd", rf_wd, 32'h77);
    tick();
    drive(2'b00, 5'd0, 0, 0, 1'b0, 5'd0, 0);
    #2;
    chk("waw_pend_after", pend_mask, 32'd0);
    chk("waw_dead_we", 32'(rf_we), 32'd0);
    chk("waw_wait", 32'(dbg_state), 32'd1);
    tick();
    #2;
    chk("waw_idle", 32'(dbg_state), 32'd0);
    tick();

    // reset mid-steal
    drive(2'b10, 5'd5, 32'h55, 0, 1'b1, 5'd9, 32'h99);
    tick();
    drive(2'b10, 5'd5, 32'h55, 0, 1'b0, 5'd0, 0);
    repeat (3) tick();
    #2;
    chk("rms_stall", 32'(pipe_stall), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rms_we", 32'(rf_we), 32'd0);
    chk("rms_wa", 32'(rf_wa), 32'd0);
    chk("rms_wd", rf_wd, 32'd0);
    chk("rms_stall0", 32'(pipe_stall), 32'd0);
    chk("rms_ready", 32'(mdu_ready), 32'd0);
    chk("rms_pend", pend_mask, 32'd0);
    @(posedge clock);
    #1;
    drive(2'b00, 5'd0, 0, 0, 1'b0, 5'd0, 0);
    reset_n = 1'b1;
    #2;
    chk("rms_post_state", 32'(dbg_state), 32'd0);
    chk("rms_post_ready", 32'(mdu_ready), 32'd1);
    chk("rms_post_pend", pend_mask, 32'd0);
    chk("rms_post_we", 32'(rf_we), 32'd0);
    tick();

    // randomized phase against the reference model
    do_reset();
    q_rd.delete(); q_data.delete(); q_live.delete();
    head_t = 0;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      logic        r_pwr_bit;
      logic [1:0]  r_ctl;
      logic [4:0]  r_rd;
      logic        r_v;
      logic [4:0]  r_mrd;
      logic [31:0] r_alu, r_mem, r_mdat;
      bit          steal, pwr, popped, was_empty, e_we, e_ready;
      logic [4:0]  e_wa;
      logic [31:0] e_wd, e_pend;

      r_pwr_bit = ($urandom_range(0, 9) < 7);
      r_ctl = {r_pwr_bit, 1'($urandom_range(0, 1))};
      r_rd = 5'($urandom_range(0, 7));
      r_alu = $urandom;
      r_mem = $urandom;
      r_v = ($urandom_range(0, 2) == 0);
      r_mrd = 5'($urandom_range(0, 7));
      r_mdat = $urandom;
      drive(r_ctl, r_rd, r_alu, r_mem, r_v, r_mrd, r_mdat);

      // expectations from the arbitration rules
      pwr = r_ctl[1] && (r_rd != 0);
      steal = (q_rd.size() > 0) && ((cyc - head_t) >= MW);
      e_ready = (q_rd.size() < 2);
      e_pend = 0;
      foreach (q_rd[i]) if (q_live[i]) e_pend |= (32'd1 << q_rd[i]);
      popped = 0;
      e_we = 0; e_wa = 0; e_wd = 0;
      if (steal) begin
        e_we = q_live[0]; e_wa = 5'(q_rd[0]); e_wd = q_data[0]; popped = 1;
      end else if (pwr) begin
        e_we = 1; e_wa = r_rd; e_wd = r_ctl[0] ? r_mem : r_alu;
      end else if (q_rd.size() > 0) begin
        e_we = q_live[0]; e_wa = 5'(q_rd[0]); e_wd = q_data[0]; popped = 1;
      end

      #2;
      chk("rnd_we", 32'(rf_we), 32'(e_we));
      if (e_we) begin
        chk("rnd_wa", 32'(rf_wa), 32'(e_wa));
        chk("rnd_wd", rf_wd, e_wd);
      end
      chk("rnd_stall", 32'(pipe_stall), 32'(steal));
      chk("rnd_ready", 32'(mdu_ready), 32'(e_ready));
      chk("rnd_pend", pend_mask, e_pend);

      // advance the model
      if (!steal && pwr) begin
        foreach (q_rd[i]) if (q_rd[i] == int'(r_rd)) q_live[i] = 0;
      end
      was_empty = (q_rd.size() == 0);
      if (popped) begin
        void'(q_rd.pop_front()); void'(q_data.pop_front()); void'(q_live.pop_front());
      end
      if (r_v && e_ready && (r_mrd != 0)) begin
        q_rd.push_back(int'(r_mrd)); q_data.push_back(r_mdat); q_live.push_back(1);
      end
      if ((popped || was_empty) && (q_rd.size() > 0)) head_t = cyc + 1;
      cyc++;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (driven from the MEM/WB pipeline register) and a long-latency multiply/divide unit (MDU) that returns results out of band. MDU results are buffered in a 2-entry queue and drained into idle writeback slots. Pipeline writes have priority. When an MDU result has waited too long, the arbiter steals one slot by stalling the pipeline for a cycle. The block sits between the MEM/WB register, the MDU and the register file; it also exports a pending-destination mask to the hazard unit.

## Interface
Parameters:
- MAX_WAIT, 8: the number of cycles the head entry may wait before a steal is forced (range 1..255).
- DEPTH, 2: the MDU result queue depth. It is fixed at 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_ctl  in  2  the MEM/WB control field. Bit 1 is RegWrite and bit 0 is MemtoReg.
- wb_mem  in  32  the MEM/WB load data.
- wb_alu  in  32  the MEM/WB ALU result.
- wb_rd  in  5  the MEM/WB destination register.
- mdu_valid  in  1  the MDU offers a result.
- mdu_ready  out  1  the queue can accept a result. It equals "not full".
- mdu_rd  in  5  the destination register of the MDU result.
- mdu_data  in  32  the MDU result value.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- pipe_stall  out  1  hold request for the MEM/WB register and the earlier pipeline stages.
- pend_mask  out  32  one bit per register that has a live buffered MDU write.

## Operation
- Pipeline request: pwr = wb_ctl[1] && wb_rd != 0. The pipeline data is wb_mem when wb_ctl[0]=1, otherwise wb_alu.
- Queue: a 2-entry FIFO whose entries are {live, rd, data}.
  - An entry is pushed when mdu_valid && mdu_ready.
  - A push with mdu_rd == 0 is accepted and discarded.
- Head age counter:
  - It clears when the head changes or when the queue is empty.
  - It otherwise increments each cycle the head is not drained, saturating at MAX_WAIT.
- FSM states:
  - IDLE: the queue is empty.
  - WAIT: the queue is non-empty and the age is below MAX_WAIT.
  - STEAL: the age equals MAX_WAIT and pwr is set.
- Port grant:
  - In STEAL: the head is written, pipe_stall=1, and the pipeline write is deferred. MEM/WB holds, so the same write appears next cycle.
  - Otherwise, if pwr: the pipeline write is performed.
  - Otherwise, if the queue is non-empty: the head is written (a dead head is popped without asserting rf_we).
  - Otherwise: rf_we=0.
- FSM transitions:
  - IDLE to WAIT on a push.
  - WAIT to STEAL when the age reaches MAX_WAIT and pwr is set.
  - STEAL always exits after one cycle, to WAIT if the queue is still non-empty, else to IDLE.
  - WAIT to IDLE when the last entry drains.
- WAW kill: when the pipeline write to register X is granted, every buffered live entry with rd == X is marked dead, because the pipeline instruction is younger. An entry pushed in the same cycle is not killed.
- pend_mask is the OR of the one-hot rd of the live entries.

## Timing
- rf_we, rf_wa and rf_wd are combinational from the inputs, the queue head and the FSM state. The write takes effect at the next clock edge, so there is no added latency for pipeline writes.
- pipe_stall is decoded from the state register only (STEAL), never from inputs.
- mdu_ready is decoded from the registered count only. A push and a pop in the same cycle are legal when the count is 1. When count=2, ready=0, so a same-cycle pop does not admit a push.
- The minimum latency for an MDU result is one cycle from push to rf_we, when the port is idle on the next cycle.
- Reset (asynchronous, can occur mid-operation):
  - The queue is emptied, the age is set to 0 and the FSM goes to IDLE.
  - While reset_n=0: rf_we=0, rf_wa=0, rf_wd=0, pipe_stall=0, mdu_ready=0 and pend_mask=0.
  - mdu_ready rises on the first cycle after release.
  - Any buffered results are lost; the MDU must be reset in the same domain.

## Structure
- Shared package wb_arb_pkg: the FSM state encoding (IDLE, WAIT, STEAL), the wb_ctl bit positions (WB_REGWRITE=1, WB_MEMTOREG=0) and the entry type {live, rd[4:0], data[31:0]}.
- Sub-module mdu_result_q: the 2-entry FIFO with a per-entry kill-by-rd port and pend_mask generation. The arbiter FSM and the age counter stay in the top level.

## Test plan
- Pipeline only: wb_ctl=2'b10, wb_rd=5, wb_alu=32'h1234 gives rf_we=1, rf_wa=5, rf_wd=32'h1234 in the same cycle. With wb_rd=0, rf_we=0.
- Idle drain: push rd=7, data=32'hCAFE with no pipeline writes. Next cycle rf_we=1, rf_wa=7, rf_wd=32'hCAFE, and pend_mask returns to 0 after the pop.
- Starvation steal: with MAX_WAIT=3, push rd=9 while pwr is held high continuously. The 4th cycle after the push is STEAL: pipe_stall=1 for exactly 1 cycle and the write goes to rd=9. The held pipeline write lands on the following cycle.
- Full queue: push rd=3 and rd=4 under continuous pwr. mdu_ready=0 and pend_mask=32'h18; a third mdu_valid is not accepted until a pop occurs.
- WAW kill: buffer rd=6, then a pipeline write to rd=6 is granted. pend_mask bit 6 clears and the entry later pops with rf_we=0.
- Reset mid-steal: assert reset_n=0 during STEAL. All outputs are 0 immediately; after release the FSM is IDLE, the queue is empty and mdu_ready=1.
